// File: rtl/alu_secuenciador_operandos.sv
// ----------------------------------------------------------------------------
// alu_secuenciador_operandos
//
// Purpose:
//   Wrapper stage around a combinational ALU. It collects operand A and then
//   operand B, one byte at a time, from an 8-bit bus using a valid/ready
//   handshake. It drives the ALU opcode and operands from registers and waits
//   a fixed settle time. It then captures the ALU result and flags, and offers
//   them to a consumer with a valid/accept handshake.
//
// Optional feature (macro ACUMULADOR_EN):
//   When the macro is defined, an A transfer with i_Usar_Acumulador=1 reuses
//   the last captured result as operand A. The byte on the bus becomes
//   operand B, and the stage goes straight to the settle wait. When the macro
//   is not defined, i_Usar_Acumulador is ignored.
//
// Parameters:
//   ANCHO         data byte width (8 for this ALU); o_Operandos is 2*ANCHO
//   LATENCIA_ALU  cycles between the operand B accept and the result
//                 capture; legal range 1..15
//
// Ports:
//   i_Clk, i_Reset          clock (rising edge), synchronous active-high reset
//   i_Dato, i_Codigo        operand byte and opcode (opcode taken with A)
//   i_Usar_Acumulador       with A: use the last result as A (ACUMULADOR_EN)
//   i_Valido / o_Listo      byte handshake
//   o_Control_ALU           registered opcode to the ALU
//   o_Operandos             registered {A,B} to the ALU
//   i_Resultado             ALU result
//   i_Banderas_Estado       ALU status flags
//   o_Resultado             captured result
//   o_Banderas              captured flags
//   o_Resultado_Valido      result valid
//   i_Resultado_Acepta      consumer accepts the result
// ----------------------------------------------------------------------------
module alu_secuenciador_operandos #(
  parameter int ANCHO        = 8,
  parameter int LATENCIA_ALU = 1
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [ANCHO-1:0]   i_Dato,
  input  logic [3:0]         i_Codigo,
  input  logic               i_Usar_Acumulador,
  input  logic               i_Valido,
  output logic               o_Listo,
  output logic [3:0]         o_Control_ALU,
  output logic [2*ANCHO-1:0] o_Operandos,
  input  logic [ANCHO-1:0]   i_Resultado,
  input  logic [2:0]         i_Banderas_Estado,
  output logic [ANCHO-1:0]   o_Resultado,
  output logic [2:0]         o_Banderas,
  output logic               o_Resultado_Valido,
  input  logic               i_Resultado_Acepta
);

  typedef enum logic [1:0] {
    ESPERA_A = 2'd0,
    ESPERA_B = 2'd1,
    CALCULA  = 2'd2,
    ENTREGA  = 2'd3
  } estado_t;

  localparam logic [3:0] CUENTA_INICIAL = 4'(LATENCIA_ALU - 1);

  estado_t                estado_q,     estado_d;
  logic                   listo_q,      listo_d;
  logic [3:0]             control_q,    control_d;
  logic [2*ANCHO-1:0]     operandos_q,  operandos_d;
  logic [ANCHO-1:0]       resultado_q,  resultado_d;
  logic [2:0]             banderas_q,   banderas_d;
  logic                   valido_q,     valido_d;
  logic [3:0]             contador_q,   contador_d;
  logic                   transfer_s;

`ifndef ACUMULADOR_EN
  // The accumulator select only matters when the feature is built in.
  logic unused_usar_acumulador_s;
  assign unused_usar_acumulador_s = i_Usar_Acumulador;
`endif

  // A byte is taken only while the stage advertises ready.
  assign transfer_s = i_Valido & listo_q;

  // Next-state and datapath update logic.
  always_comb begin
    estado_d    = estado_q;
    control_d   = control_q;
    operandos_d = operandos_q;
    resultado_d = resultado_q;
    banderas_d  = banderas_q;
    valido_d    = valido_q;
    contador_d  = contador_q;
    case (estado_q)
      ESPERA_A: begin
        if (transfer_s) begin
          control_d = i_Codigo;
`ifdef ACUMULADOR_EN
          if (i_Usar_Acumulador) begin
            // The last captured result becomes A and the bus byte becomes B.
            operandos_d = {resultado_q, i_Dato};
            contador_d  = CUENTA_INICIAL;
            estado_d    = CALCULA;
          end else begin
            operandos_d[2*ANCHO-1:ANCHO] = i_Dato;
            estado_d                     = ESPERA_B;
          end
`else
          operandos_d[2*ANCHO-1:ANCHO] = i_Dato;
          estado_d                     = ESPERA_B;
`endif
        end else begin
          estado_d = ESPERA_A;
        end
      end
      ESPERA_B: begin
        if (transfer_s) begin
          operandos_d[ANCHO-1:0] = i_Dato;
          contador_d             = CUENTA_INICIAL;
          estado_d               = CALCULA;
        end else begin
          estado_d = ESPERA_B;
        end
      end
      CALCULA: begin
        // The operands stay frozen here, so the ALU output is stable at capture.
        if (contador_q == 4'd0) begin
          resultado_d = i_Resultado;
          banderas_d  = i_Banderas_Estado;
          valido_d    = 1'b1;
          estado_d    = ENTREGA;
        end else begin
          contador_d = contador_q - 4'd1;
        end
      end
      ENTREGA: begin
        if (i_Resultado_Acepta) begin
          valido_d = 1'b0;
          estado_d = ESPERA_A;
        end else begin
          valido_d = 1'b1;
        end
      end
      default: begin
        estado_d = ESPERA_A;
        valido_d = 1'b0;
      end
    endcase
    // Ready is registered from the next state. It rises in the same cycle
    // that valid falls.
    listo_d = (estado_d == ESPERA_A) || (estado_d == ESPERA_B);
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      estado_q    <= ESPERA_A;
      listo_q     <= 1'b1;
      control_q   <= 4'd0;
      operandos_q <= '0;
      resultado_q <= '0;
      banderas_q  <= 3'd0;
      valido_q    <= 1'b0;
      contador_q  <= 4'd0;
    end else begin
      estado_q    <= estado_d;
      listo_q     <= listo_d;
      control_q   <= control_d;
      operandos_q <= operandos_d;
      resultado_q <= resultado_d;
      banderas_q  <= banderas_d;
      valido_q    <= valido_d;
      contador_q  <= contador_d;
    end
  end

  assign o_Listo            = listo_q;
  assign o_Control_ALU      = control_q;
  assign o_Operandos        = operandos_q;
  assign o_Resultado        = resultado_q;
  assign o_Banderas         = banderas_q;
  assign o_Resultado_Valido = valido_q;

endmodule

// File: tb/tb_alu_secuenciador_operandos.sv
// ----------------------------------------------------------------------------
// tb_alu_secuenciador_operandos
//
// Directed bench for alu_secuenciador_operandos with LATENCIA_ALU=4. A small
// combinational ALU model sits behind the stage. Inputs change and outputs are
// sampled on the falling clock edge.
//
// ALU model opcodes:
//   4'b1000  add
//   4'b1001  sub
//   4'b1010  and
//   other    xor
// Flags are {carry/borrow, overflow, zero}.
// ----------------------------------------------------------------------------
module tb_alu_secuenciador_operandos;

  localparam int LAT = 4;

  logic        i_Clk;
  logic        i_Reset;
  logic [7:0]  i_Dato;
  logic [3:0]  i_Codigo;
  logic        i_Usar_Acumulador;
  logic        i_Valido;
  logic        o_Listo;
  logic [3:0]  o_Control_ALU;
  logic [15:0] o_Operandos;
  logic [7:0]  i_Resultado;
  logic [2:0]  i_Banderas_Estado;
  logic [7:0]  o_Resultado;
  logic [2:0]  o_Banderas;
  logic        o_Resultado_Valido;
  logic        i_Resultado_Acepta;

  int checks;
  int failures;

  alu_secuenciador_operandos #(.ANCHO(8), .LATENCIA_ALU(LAT)) dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_Dato             (i_Dato),
    .i_Codigo           (i_Codigo),
    .i_Usar_Acumulador  (i_Usar_Acumulador),
    .i_Valido           (i_Valido),
    .o_Listo            (o_Listo),
    .o_Control_ALU      (o_Control_ALU),
    .o_Operandos        (o_Operandos),
    .i_Resultado        (i_Resultado),
    .i_Banderas_Estado  (i_Banderas_Estado),
    .o_Resultado        (o_Resultado),
    .o_Banderas         (o_Banderas),
    .o_Resultado_Valido (o_Resultado_Valido),
    .i_Resultado_Acepta (i_Resultado_Acepta)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Combinational ALU model driven by the registered opcode and operands.
  logic [7:0] alu_a, alu_b;
  logic [8:0] alu_ext;
  always_comb begin
    alu_a   = o_Operandos[15:8];
    alu_b   = o_Operandos[7:0];
    alu_ext = 9'd0;
    i_Banderas_Estado = 3'b000;
    case (o_Control_ALU)
      4'b1000: begin
        alu_ext = {1'b0, alu_a} + {1'b0, alu_b};
        i_Banderas_Estado[1] = (alu_a[7] == alu_b[7]) && (alu_ext[7] != alu_a[7]);
      end
      4'b1001: begin
        alu_ext = {1'b0, alu_a} - {1'b0, alu_b};
        i_Banderas_Estado[1] = (alu_a[7] != alu_b[7]) && (alu_ext[7] != alu_a[7]);
      end
      4'b1010: alu_ext = {1'b0, alu_a & alu_b};
      default: alu_ext = {1'b0, alu_a ^ alu_b};
    endcase
    i_Resultado          = alu_ext[7:0];
    i_Banderas_Estado[2] = alu_ext[8];
    i_Banderas_Estado[0] = (alu_ext[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_Reset = 1'b1; i_Dato = 8'h00; i_Codigo = 4'd0; i_Usar_Acumulador = 1'b0;
    i_Valido = 1'b0; i_Resultado_Acepta = 1'b0;

    // 1. Reset held for two cycles.
    step(); step();
    check("rst_valid",     16'(o_Resultado_Valido), 16'h0);
    check("rst_operandos", o_Operandos,             16'h0000);
    check("rst_control",   16'(o_Control_ALU),      16'h0);
    check("rst_resultado", 16'(o_Resultado),        16'h00);
    check("rst_banderas",  16'(o_Banderas),         16'h0);
    i_Reset = 1'b0;
    check("rst_listo", 16'(o_Listo), 16'h1);
    step();
    check("idle_listo", 16'(o_Listo), 16'h1);

    // 2. 8'h7F + 8'h01 with opcode 4'b1000.
    i_Codigo = 4'b1000; i_Dato = 8'h7F; i_Valido = 1'b1;
    step();
    check("a_operando", 16'(o_Operandos[15:8]), 16'h7F);
    check("a_control",  16'(o_Control_ALU),     16'h8);
    check("a_listo",    16'(o_Listo),           16'h1);
    i_Codigo = 4'b0000; i_Dato = 8'h01;
    step();
    i_Valido = 1'b0;
    check("b_operandos", o_Operandos,        16'h7F01);
    check("b_control",   16'(o_Control_ALU), 16'h8);
    check("b_listo",     16'(o_Listo),       16'h0);
    // Valid must appear exactly LAT edges after the B transfer edge.
    for (int k = 1; k < LAT; k++) begin
      step();
      check("calc_valid_low", 16'(o_Resultado_Valido), 16'h0);
      check("calc_operandos", o_Operandos,             16'h7F01);
    end
    step();
    check("res_valid",    16'(o_Resultado_Valido), 16'h1);
    check("res_resultado", 16'(o_Resultado),       16'h80);
    check("res_banderas", 16'(o_Banderas),         16'h2);

    // 3. Backpressure while the bus keeps offering a byte.
    i_Valido = 1'b1; i_Dato = 8'hAA; i_Codigo = 4'hF; i_Resultado_Acepta = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_listo",     16'(o_Listo),            16'h0);
      check("bp_valid",     16'(o_Resultado_Valido), 16'h1);
      check("bp_resultado", 16'(o_Resultado),        16'h80);
      check("bp_operandos", o_Operandos,             16'h7F01);
    end
    i_Resultado_Acepta = 1'b1; i_Valido = 1'b0;
    step();
    i_Resultado_Acepta = 1'b0;
    check("acc_valid",     16'(o_Resultado_Valido), 16'h0);
    check("acc_listo",     16'(o_Listo),            16'h1);
    check("acc_operandos", o_Operandos,             16'h7F01);
    check("acc_control",   16'(o_Control_ALU),      16'h8);

    // 4. i_Valido toggles every cycle: 8'hEE - 8'hF7 with opcode 4'b1001.
    i_Codigo = 4'b1001; i_Dato = 8'hEE; i_Valido = 1'b1;
    step();
    check("tg_a",       16'(o_Operandos[15:8]), 16'hEE);
    check("tg_control", 16'(o_Control_ALU),     16'h9);
    i_Valido = 1'b0; i_Dato = 8'h55;
    step();
    check("tg_gap_b",     16'(o_Operandos[7:0]), 16'h01);
    check("tg_gap_listo", 16'(o_Listo),          16'h1);
    i_Valido = 1'b1; i_Dato = 8'hF7;
    step();
    check("tg_operandos", o_Operandos,   16'hEEF7);
    check("tg_listo",     16'(o_Listo),  16'h0);
    i_Dato = 8'h33;
    for (int k = 1; k <= LAT; k++) begin
      i_Valido = ~i_Valido;
      step();
      check("tg_hold", o_Operandos, 16'hEEF7);
    end
    check("tg_valid",     16'(o_Resultado_Valido), 16'h1);
    check("tg_resultado", 16'(o_Resultado),        16'hF7);
    check("tg_banderas",  16'(o_Banderas),         16'h4);
    i_Valido = 1'b0; i_Resultado_Acepta = 1'b1;
    step();
    i_Resultado_Acepta = 1'b0;
    check("tg_acc_valid", 16'(o_Resultado_Valido), 16'h0);

    // 5. Reset two cycles into the settle wait.
    i_Codigo = 4'b1000; i_Dato = 8'h10; i_Valido = 1'b1;
    step();
    i_Dato = 8'h20;
    step();
    i_Valido = 1'b0;
    step(); step();
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    check("mrst_valid",     16'(o_Resultado_Valido), 16'h0);
    check("mrst_operandos", o_Operandos,             16'h0000);
    check("mrst_control",   16'(o_Control_ALU),      16'h0);
    check("mrst_resultado", 16'(o_Resultado),        16'h00);
    check("mrst_listo",     16'(o_Listo),            16'h1);
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      check("mrst_no_pulse", 16'(o_Resultado_Valido), 16'h0);
    end
    i_Codigo = 4'b1000; i_Dato = 8'h02; i_Valido = 1'b1;
    step();
    i_Dato = 8'h03;
    step();
    i_Valido = 1'b0;
    for (int k = 0; k < LAT; k++) step();
    check("post_valid",     16'(o_Resultado_Valido), 16'h1);
    check("post_resultado", 16'(o_Resultado),        16'h05);
    check("post_banderas",  16'(o_Banderas),         16'h0);
    i_Resultado_Acepta = 1'b1;
    step();
    i_Resultado_Acepta = 1'b0;

    // 6. Accumulator request with 8'h03 and opcode 4'b1010, 8'h05 held.
    i_Usar_Acumulador = 1'b1; i_Dato = 8'h03; i_Codigo = 4'b1010; i_Valido = 1'b1;
    step();
    i_Valido = 1'b0; i_Usar_Acumulador = 1'b0;
    check("ac_control", 16'(o_Control_ALU), 16'hA);
`ifdef ACUMULADOR_EN
    check("ac_operandos", o_Operandos,  16'h0503);
    check("ac_listo",     16'(o_Listo), 16'h0);
    for (int k = 0; k < LAT; k++) step();
    check("ac_valid",     16'(o_Resultado_Valido), 16'h1);
    check("ac_resultado", 16'(o_Resultado),        16'h01);
`else
    check("ac_operando_a", 16'(o_Operandos[15:8]), 16'h03);
    check("ac_listo",      16'(o_Listo),           16'h1);
    step();
    check("ac_wait_b",  16'(o_Listo),            16'h1);
    check("ac_novalid", 16'(o_Resultado_Valido), 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
